pll_lock_supervisor: RTL

//  Controls the board PLL and supervises its lock. Runs on the free-running board clock i_clk, never on the PLL output.

---
 rtl/pll_lock_supervisor.sv | 118 +++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL control and lock supervision on the free-running board clock.
// Drives PLL areset, qualifies lock, and sequences the core reset.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int ARESET_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RST_HOLD       = 16,
    parameter int CNT_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_locked,
    output logic             o_pll_areset,
    output logic             o_rst,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_loss_count,
    output logic [CNT_W-1:0] o_retry_count
);

    localparam int MAX_AB = (ARESET_CYCLES > TIMEOUT_CYCLES) ?
                            ARESET_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CD = (STABLE_CYCLES > RST_HOLD) ?
                            STABLE_CYCLES : RST_HOLD;
    localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] ARESET_LAST  = CW'(ARESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] SAT       = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        QUALIFY,
        RELEASE,
        RUN
    } state_t;

    state_t                 state;
    state_t                 nxt;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic                   bump_loss;
    logic                   bump_retry;

    assign locked_s = sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_locked};
        end
    end

    // A dropped lock always wins over an expiring cycle count.
    always_comb begin
        nxt        = state;
        bump_loss  = 1'b0;
        bump_retry = 1'b0;
        unique case (state)
            RESET_PLL: begin
                if (cnt == ARESET_LAST) nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    nxt = QUALIFY;
                end else if (cnt == TIMEOUT_LAST) begin
                    nxt        = RESET_PLL;
                    bump_retry = 1'b1;
                end
            end
            QUALIFY: begin
                if (!locked_s)               nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST) nxt = RELEASE;
            end
            RELEASE: begin
                if (!locked_s)             nxt = WAIT_LOCK;
                else if (cnt == HOLD_LAST) nxt = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    nxt       = WAIT_LOCK;
                    bump_loss = 1'b1;
                end
            end
            default: nxt = RESET_PLL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            o_pll_areset  <= 1'b1;
            o_rst         <= 1'b1;
            o_ready       <= 1'b0;
            o_loss_count  <= '0;
            o_retry_count <= '0;
        end else begin
            state <= nxt;
            if (nxt != state)     cnt <= '0;
            else if (state != RUN) cnt <= cnt + 1'b1;
            o_pll_areset <= (nxt == RESET_PLL);
            o_rst        <= (nxt != RUN);
            o_ready      <= (nxt == RUN);
            if (bump_loss && o_loss_count != SAT)
                o_loss_count <= o_loss_count + 1'b1;
            if (bump_retry && o_retry_count != SAT)
                o_retry_count <= o_retry_count + 1'b1;
        end
    end

endmodule
